acia_rx_fifo: RTL and testbench
===============================

ACIA_RX_FIFO -- requirements
Module: acia_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of byte entries; power of two, range 2..256.
REQ-002 SHALL have parameter CW, default $clog2(DEPTH)+1: width of count_o; fixed derived value, not overridden.
REQ-003 SHALL have the single clock domain `clk`; reset `rst_i` is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous active-high system/ACIA reset.
REQ-006 SHALL have port rx_dat_i  input  8  received byte from the serial receive stage.
REQ-007 SHALL have port rx_stb_i  input  1  single-cycle strobe, rx_dat_i valid this cycle.
REQ-008 SHALL have port rd_i  input  1  pop request from the register interface, one entry per asserted cycle.
REQ-009 SHALL have port flush_i  input  1  synchronous discard of all entries.
REQ-010 SHALL have port ovr_clr_i  input  1  clears sticky overrun flag.
REQ-011 SHALL have port rd_dat_o  output  8  head-of-queue byte (show-ahead).
REQ-012 SHALL have port rd_valid_o  output  1  queue non-empty, rd_dat_o meaningful.
REQ-013 SHALL have port full_o  output  1  count_o == DEPTH.
REQ-014 SHALL have port count_o  output  CW  entries held, 0..DEPTH.
REQ-015 SHALL have port ovr_o  output  1  sticky overrun: a byte was dropped.

Function
REQ-016 SHALL store bytes in a DEPTH-entry array addressed by write and read pointers of $clog2(DEPTH) bits, each wrapping modulo DEPTH.
REQ-017 SHALL push (write rx_dat_i at write pointer, increment it) on a cycle with rx_stb_i=1 when not full, or when full and a pop occurs in the same cycle.
REQ-018 SHALL pop (increment read pointer) on a cycle with rd_i=1 and rd_valid_o=1; rd_i while empty is ignored without pointer or count change.
REQ-019 SHALL update count_o: +1 push only, -1 pop only, unchanged on push+pop or neither; never exceeds DEPTH nor underflows.
REQ-020 SHALL, on push into an empty queue, assert rd_valid_o and present the byte on rd_dat_o on the next cycle (latency 1); simultaneous rd_i while empty does not pop that byte.
REQ-021 SHALL, after a pop, present the next entry on rd_dat_o the following cycle; rd_dat_o holds its last value when empty.
REQ-022 SHALL, on rx_stb_i=1 while full with no pop, drop the byte (storage unchanged) and set ovr_o the next cycle.
REQ-023 SHALL keep ovr_o set until ovr_clr_i=1; if set and clear coincide, set wins.
REQ-024 SHALL, on flush_i=1, zero both pointers and count_o next cycle; any push/pop in that cycle is discarded; ovr_o unaffected.
REQ-025 SHALL drive full_o, rd_valid_o combinationally from registered count (full_o = count==DEPTH, rd_valid_o = count!=0).
REQ-026 SHALL treat rx_stb_i as at most one byte per cycle; no handshake back to the receive stage exists.

Reset
REQ-027 SHALL, while rst_i=1 (asserted asynchronously), clear pointers, count_o=0, rd_valid_o=0, full_o=0, ovr_o=0, rd_dat_o=8'h00; array contents need not be reset.
REQ-028 SHALL discard any in-progress push/pop on reset assertion mid-operation; first push after release behaves as into an empty queue.

Verification
REQ-029 SHALL verify: after reset, strobe 8'h41 one cycle -> next cycle rd_valid_o=1, rd_dat_o=8'h41, count_o=1; pulse rd_i -> rd_valid_o=0, count_o=0.
REQ-030 SHALL verify: DEPTH=16, push 16 bytes 8'h00..8'h0F -> full_o=1, count_o=16; 17th strobe 8'hAA -> ovr_o=1, count_o=16; 16 pops yield 8'h00..8'h0F in order, no 8'hAA.
REQ-031 SHALL verify: full queue, rx_stb_i=1 (8'h55) and rd_i=1 same cycle -> count_o stays 16, ovr_o stays 0, 8'h55 emerges last after 16 pops.
REQ-032 SHALL verify wrap-around: 40 push/pop pairs of incrementing bytes at varied occupancy -> output sequence matches input exactly, count_o tracks a reference model.
REQ-033 SHALL verify: ovr_o=1, ovr_clr_i=1 with overflowing strobe same cycle -> ovr_o remains 1; next cycle ovr_clr_i alone -> ovr_o=0.
REQ-034 SHALL verify: 5 entries held, assert flush_i with rx_stb_i=1 -> count_o=0, rd_valid_o=0 next cycle; assert rst_i mid-stream asynchronously -> outputs zero before next clock edge.

Source files
------------

// File: rtl/acia_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : acia_rx_fifo
//  Description : ACIA receive queue. Show-ahead byte FIFO between the serial
//                receive stage and the register interface, with a sticky
//                overrun flag and a synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module acia_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic [7:0]    rx_dat_i,
    input  logic          rx_stb_i,
    input  logic          rd_i,
    input  logic          flush_i,
    input  logic          ovr_clr_i,
    output logic [7:0]    rd_dat_o,
    output logic          rd_valid_o,
    output logic          full_o,
    output logic [CW-1:0] count_o,
    output logic          ovr_o
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovr_q,    ovr_d;
    logic [7:0]    rd_dat_q, rd_dat_d;

    logic          w_push;
    logic          w_pop;
    logic          w_ovf;

    assign full_o     = (count_q == C_DEPTH);
    assign rd_valid_o = (count_q != '0);
    assign count_o    = count_q;
    assign ovr_o      = ovr_q;
    assign rd_dat_o   = rd_dat_q;

    // A pop needs data present; a push into a full queue is allowed only when
    // the same cycle frees a slot. Flush cancels both.
    assign w_pop  = rd_i && rd_valid_o && !flush_i;
    assign w_push = rx_stb_i && (!full_o || w_pop) && !flush_i;
    assign w_ovf  = rx_stb_i && full_o && !rd_i;

    // Next-state: pointers, occupancy, overrun flag and the show-ahead head byte.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rd_dat_d = rd_dat_q;
        ovr_d    = ovr_q;

        // Setting wins over clearing so a coincident drop is never lost.
        if (w_ovf) begin
            ovr_d = 1'b1;
        end else if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + CW'(1);
            end else if (w_pop && !w_push) begin
                count_d = count_q - CW'(1);
            end
            // The new head may be the byte being written this cycle (push into
            // an empty queue, or push+pop with a single entry held); bypass it
            // since the array write has not landed yet. Empty keeps last value.
            if (count_d != '0) begin
                if (w_push && (wr_ptr_q == rd_ptr_d)) begin
                    rd_dat_d = rx_dat_i;
                end else begin
                    rd_dat_d = mem_q[rd_ptr_d];
                end
            end
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= rx_dat_i;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            rd_dat_q <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            rd_dat_q <= rd_dat_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acia_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acia_rx_fifo
//  Description : Self-checking bench for acia_rx_fifo: directed vector table,
//                hand sequences for full/overrun/flush/reset corners, and
//                random traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acia_rx_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          rst_i     = 1'b1;
    logic [7:0]    rx_dat_i  = 8'h00;
    logic          rx_stb_i  = 1'b0;
    logic          rd_i      = 1'b0;
    logic          flush_i   = 1'b0;
    logic          ovr_clr_i = 1'b0;
    logic [7:0]    rd_dat_o;
    logic          rd_valid_o;
    logic          full_o;
    logic [CW-1:0] count_o;
    logic          ovr_o;

    acia_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .rx_dat_i   (rx_dat_i),
        .rx_stb_i   (rx_stb_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .ovr_clr_i  (ovr_clr_i),
        .rd_dat_o   (rd_dat_o),
        .rd_valid_o (rd_valid_o),
        .full_o     (full_o),
        .count_o    (count_o),
        .ovr_o      (ovr_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the queue contents, the sticky flag, the last head byte.
    byte unsigned mq[$];
    bit           m_ovr = 1'b0;
    logic [7:0]   m_dat = 8'h00;

    typedef struct {
        bit         stb;
        logic [7:0] dat;
        bit         rd;
        bit         fl;
        bit         clr;
        int         cnt;
        bit         vld;
        logic [7:0] odat;
        bit         full;
        bit         ovr;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_count", int'(count_o), mq.size());
        chk("model_valid", int'(rd_valid_o), int'(mq.size() != 0));
        chk("model_full",  int'(full_o), int'(mq.size() == DEPTH));
        chk("model_dat",   int'(rd_dat_o), int'(m_dat));
        chk("model_ovr",   int'(ovr_o), int'(m_ovr));
    endtask

    // One clock of stimulus, then advance the model and compare.
    task automatic step(input bit stb, input logic [7:0] dat, input bit rd,
                        input bit fl, input bit clr);
        int n;
        bit pop, push, ovf;
        @(negedge clk);
        rx_stb_i  = stb;
        rx_dat_i  = dat;
        rd_i      = rd;
        flush_i   = fl;
        ovr_clr_i = clr;
        n    = mq.size();
        pop  = rd && (n > 0);
        push = stb && ((n < DEPTH) || pop);
        ovf  = stb && (n == DEPTH) && !rd;
        @(posedge clk);
        #1;
        if (ovf) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(dat);
        end
        if (mq.size() > 0) m_dat = mq[0];
        check_model();
    endtask

    task automatic async_reset();
        @(negedge clk);
        rx_stb_i = 1'b1;
        rx_dat_i = 8'h77;
        rd_i     = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        chk("arst_count", int'(count_o), 0);
        chk("arst_valid", int'(rd_valid_o), 0);
        chk("arst_full",  int'(full_o), 0);
        chk("arst_ovr",   int'(ovr_o), 0);
        chk("arst_dat",   int'(rd_dat_o), 0);
        @(negedge clk);
        rx_stb_i = 1'b0;
        rd_i     = 1'b0;
        rst_i    = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        m_dat = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, 8'h41, 0, 0, 0, 1, 1, 8'h41, 0, 0};
        tbl[1]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h41, 0, 0};
        tbl[2]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h41, 0, 0};
        tbl[3]  = '{1, 8'h42, 1, 0, 0, 1, 1, 8'h42, 0, 0};
        tbl[4]  = '{1, 8'h43, 0, 0, 0, 2, 1, 8'h42, 0, 0};
        tbl[5]  = '{1, 8'h44, 1, 0, 0, 2, 1, 8'h43, 0, 0};
        tbl[6]  = '{0, 8'h00, 1, 0, 0, 1, 1, 8'h44, 0, 0};
        tbl[7]  = '{0, 8'h00, 0, 0, 1, 1, 1, 8'h44, 0, 0};
        tbl[8]  = '{1, 8'h99, 0, 1, 0, 0, 0, 8'h44, 0, 0};
        tbl[9]  = '{1, 8'h5A, 0, 0, 0, 1, 1, 8'h5A, 0, 0};
        tbl[10] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h5A, 0, 0};
        tbl[11] = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h5A, 0, 0};

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("rst_count", int'(count_o), 0);
        chk("rst_valid", int'(rd_valid_o), 0);
        chk("rst_full",  int'(full_o), 0);
        chk("rst_ovr",   int'(ovr_o), 0);
        chk("rst_dat",   int'(rd_dat_o), 0);
        rst_i = 1'b0;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].stb, tbl[i].dat, tbl[i].rd, tbl[i].fl, tbl[i].clr);
            chk("vec_count", int'(count_o),    tbl[i].cnt);
            chk("vec_valid", int'(rd_valid_o), int'(tbl[i].vld));
            chk("vec_dat",   int'(rd_dat_o),   int'(tbl[i].odat));
            chk("vec_full",  int'(full_o),     int'(tbl[i].full));
            chk("vec_ovr",   int'(ovr_o),      int'(tbl[i].ovr));
        end

        // Fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
        chk("fill_full",  int'(full_o), 1);
        chk("fill_count", int'(count_o), DEPTH);
        step(1, 8'hAA, 0, 0, 0);
        chk("ovf_ovr",   int'(ovr_o), 1);
        chk("ovf_count", int'(count_o), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", int'(rd_dat_o), i);
            step(0, 8'h00, 1, 0, 0);
        end
        chk("drain_valid", int'(rd_valid_o), 0);
        step(0, 8'h00, 0, 0, 1);

        // Push and pop together while full
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
        step(1, 8'h55, 1, 0, 0);
        chk("pp_count", int'(count_o), DEPTH);
        chk("pp_ovr",   int'(ovr_o), 0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("pp_order", int'(rd_dat_o), (i < DEPTH - 1) ? (8'h11 + i) : 8'h55);
            step(0, 8'h00, 1, 0, 0);
        end

        // Overrun set beats clear
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        step(1, 8'hBB, 0, 0, 0);
        chk("ovr_set", int'(ovr_o), 1);
        step(1, 8'hCC, 0, 0, 1);
        chk("ovr_setwins", int'(ovr_o), 1);
        step(0, 8'h00, 0, 0, 1);
        chk("ovr_clear", int'(ovr_o), 0);
        step(0, 8'h00, 0, 1, 0);

        // Flush with a coincident strobe, then asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
        chk("pre_flush_count", int'(count_o), 5);
        step(1, 8'h66, 0, 1, 0);
        chk("flush_count", int'(count_o), 0);
        chk("flush_valid", int'(rd_valid_o), 0);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        async_reset();
        step(1, 8'h12, 1, 0, 0);
        chk("post_rst_dat",   int'(rd_dat_o), 8'h12);
        chk("post_rst_count", int'(count_o), 1);
        step(0, 8'h00, 1, 0, 0);

        // Wrap-around: incrementing bytes at varying occupancy
        for (int i = 0; i < 40; i++) step(1, 8'(i), mq.size() > (i % 6), 0, 0);
        while (mq.size() > 0) step(0, 8'h00, 1, 0, 0);

        // Random traffic: fill-biased, then drain-biased
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), 8'($urandom),
                 (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
